// File: rtl/bram_sdp.sv
// Simple dual-port block RAM with byte-lane writes, registered read and a full-memory clear engine.
// Optional macro BRAM_SDP_BYPASS_EN: a same-address read/write collision returns write-first data.
module bram_sdp #(
  parameter int               WIDTH          = 32,
  parameter int               ADDR_WIDTH     = 9,
  parameter logic [WIDTH-1:0] CLEAR_VALUE    = {WIDTH{1'b0}},
  parameter bit               CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [WIDTH/8-1:0]      wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    clr_req,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  output logic                    busy
);

  localparam int NB    = WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  logic [WIDTH-1:0]      mem_r [DEPTH];
  state_t                state_r;
  state_t                state_nx_s;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [ADDR_WIDTH-1:0] cnt_nx_s;
  logic [WIDTH-1:0]      rd_data_r;
  logic                  rd_valid_r;

  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic [WIDTH-1:0]      mem_data_s;
  logic [NB-1:0]         mem_be_s;
  logic                  rd_fire_s;
  logic [WIDTH-1:0]      rd_word_s;

  // Clear engine next-state: counter stops at the last address instead of wrapping
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          state_nx_s = CLEAR;
          cnt_nx_s   = {ADDR_WIDTH{1'b0}};
        end else begin
          state_nx_s = IDLE;
        end
      end
      CLEAR: begin
        if (cnt_r == LAST_ADDR) begin
          state_nx_s = IDLE;
        end else begin
          cnt_nx_s = cnt_r + ADDR_ONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // FSM state and clear counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt_r   <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Write port mux: the clear engine owns the port while busy; reset blocks all writes
  always_comb begin
    if (state_r == CLEAR) begin
      mem_we_s   = ~rst;
      mem_addr_s = cnt_r;
      mem_data_s = CLEAR_VALUE;
      mem_be_s   = {NB{1'b1}};
    end else begin
      mem_we_s   = wr_en & ~rst;
      mem_addr_s = wr_addr;
      mem_data_s = wr_data;
      mem_be_s   = wr_be;
    end
  end

  // Storage array with per-lane write enables, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be_s[i]) begin
          mem_r[mem_addr_s][8*i +: 8] <= mem_data_s[8*i +: 8];
        end
      end
    end
  end

  assign rd_fire_s = rd_en & (state_r == IDLE) & ~rst;

`ifdef BRAM_SDP_BYPASS_EN
  logic collide_s;
  assign collide_s = wr_en & (state_r == IDLE) & (wr_addr == rd_addr);

  // Forward enabled write lanes on a same-address collision
  always_comb begin
    rd_word_s = mem_r[rd_addr];
    for (int i = 0; i < NB; i++) begin
      if (collide_s && wr_be[i]) begin
        rd_word_s[8*i +: 8] = wr_data[8*i +: 8];
      end else begin
        rd_word_s[8*i +: 8] = mem_r[rd_addr][8*i +: 8];
      end
    end
  end
`else
  assign rd_word_s = mem_r[rd_addr];
`endif

  // Registered read port; data holds when no read is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= {WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_fire_s;
      if (rd_fire_s) begin
        rd_data_r <= rd_word_s;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = (state_r == CLEAR);

endmodule
